vck190_axil_responder: RTL and testbench

AXI4-Lite responder that gives the PCIe host, through the CPM master path into the PL, a control/status register window for the VCK190 tester. It decodes host reads and writes against a fixed register map: ID, control, sticky status, 64-bit cycle counter and scratch registers. It drives control strobes into the tester datapath and returns SLVERR for unmapped offsets. It sits between the CPM block-design AXI master port and the tester logic, on the PCIe user clock.

---
 rtl/vck190_tester_pkg.sv | 33 +++
 rtl/vck190_axil_responder_if.sv | 38 +++
 rtl/vck190_axil_responder_wr_join.sv | 78 +++++++
 rtl/vck190_axil_responder.sv | 173 +++++++++++++++++
 tb/tb_vck190_axil_responder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vck190_tester_pkg.sv
// Shared constants for the VCK190 tester register window.
// Covers the register offsets, the AXI response codes and the byte-strobe merge helper.
package vck190_tester_pkg;

    localparam logic [11:0] OFF_ID      = 12'h000;
    localparam logic [11:0] OFF_CTRL    = 12'h004;
    localparam logic [11:0] OFF_STATUS  = 12'h008;
    localparam logic [11:0] OFF_CYC_LO  = 12'h00C;
    localparam logic [11:0] OFF_CYC_HI  = 12'h010;
    localparam logic [11:0] OFF_SCR0    = 12'h020;
    localparam logic [11:0] OFF_SCR1    = 12'h024;
    localparam logic [11:0] OFF_SCR2    = 12'h028;
    localparam logic [11:0] OFF_SCR3    = 12'h02C;

    localparam logic [31:0] DEAD_BEEF   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespSlverr = 2'b10
    } axi_resp_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/vck190_axil_responder_if.sv
// AXI4-Lite bundle between the CPM master path and the tester register window.
interface vck190_axil_responder_if #(
    parameter int unsigned ADDR_W = 12
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/vck190_axil_responder_wr_join.sv
// Independent AW and W capture buffers that join into a single write-commit strobe.
// A channel arriving in the commit cycle bypasses its buffer, so an aligned AW+W commits at once.
module axil_wr_join
    import vck190_tester_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    input  logic              i_b_busy,
    output logic              o_commit,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_data,
    output logic [3:0]        o_strb
);

    logic              r_aw_full;
    logic [ADDR_W-1:0] r_aw_addr;
    logic              r_w_full;
    logic [31:0]       r_w_data;
    logic [3:0]        r_w_strb;
    logic              r_awready;
    logic              r_wready;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_have;
    logic w_w_have;
    logic w_aw_full_next;
    logic w_w_full_next;

    assign w_aw_hs   = i_awvalid & r_awready;
    assign w_w_hs    = i_wvalid & r_wready;
    assign w_aw_have = r_aw_full | w_aw_hs;
    assign w_w_have  = r_w_full | w_w_hs;

    assign o_commit  = w_aw_have & w_w_have & ~i_b_busy;
    assign o_addr    = r_aw_full ? r_aw_addr : i_awaddr;
    assign o_data    = r_w_full ? r_w_data : i_wdata;
    assign o_strb    = r_w_full ? r_w_strb : i_wstrb;

    assign w_aw_full_next = w_aw_have & ~o_commit;
    assign w_w_full_next  = w_w_have & ~o_commit;

    assign o_awready = r_awready;
    assign o_wready  = r_wready;

    // Ready flops are registered copies of "buffer empty next cycle" so they stay low in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
        end else begin
            r_aw_full <= w_aw_full_next;
            r_w_full  <= w_w_full_next;
            r_awready <= ~w_aw_full_next;
            r_wready  <= ~w_w_full_next;
            if (w_aw_hs) r_aw_addr <= i_awaddr;
            if (w_w_hs) begin
                r_w_data <= i_wdata;
                r_w_strb <= i_wstrb;
            end
        end
    end

endmodule

// File: rtl/vck190_axil_responder.sv
// AXI4-Lite control/status window for the VCK190 tester on the PCIe user clock.
// Holds ID, CTRL, sticky STATUS, a 64-bit cycle counter with coherent HI shadow and scratch.
module vck190_axil_responder
    import vck190_tester_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] ID_VALUE = 32'h1900_0001
) (
    input  logic                   PCIE_user_Clk,
    input  logic                   PCIE_user_Rst_n,
    vck190_axil_responder_if.slave s_axil,
    output logic                   ctrl_start_o,
    output logic                   ctrl_enable_o,
    input  logic                   tst_busy_i,
    input  logic                   tst_done_i
);

    logic [63:0] r_cycle;
    logic [31:0] r_cyc_shadow;
    logic [31:0] r_scratch [4];
    logic        r_enable;
    logic        r_start;
    logic        r_done;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic              w_commit;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [31:0]       w_wr_data;
    logic [3:0]        w_wr_strb;
    logic [11:0]       w_wr_off;
    logic [11:0]       w_rd_off;
    axi_resp_e         w_wr_resp;
    logic              w_sel_ctrl;
    logic              w_sel_status;
    logic [3:0]        w_sel_scr;
    logic              w_done_clr;
    logic              w_ar_hs;
    logic              w_rvalid_next;
    logic [31:0]       w_rd_data;
    axi_resp_e         w_rd_resp;
    logic              w_unused;

    axil_wr_join #(
        .ADDR_W (ADDR_W)
    ) u_wr_join (
        .i_clk     (PCIE_user_Clk),
        .i_rst_n   (PCIE_user_Rst_n),
        .i_awaddr  (s_axil.awaddr),
        .i_awvalid (s_axil.awvalid),
        .o_awready (s_axil.awready),
        .i_wdata   (s_axil.wdata),
        .i_wstrb   (s_axil.wstrb),
        .i_wvalid  (s_axil.wvalid),
        .o_wready  (s_axil.wready),
        .i_b_busy  (r_bvalid),
        .o_commit  (w_commit),
        .o_addr    (w_wr_addr),
        .o_data    (w_wr_data),
        .o_strb    (w_wr_strb)
    );

    assign w_wr_off = {w_wr_addr[11:2], 2'b00};
    assign w_rd_off = {s_axil.araddr[11:2], 2'b00};
    assign w_unused = ^{w_wr_addr[1:0], s_axil.araddr[1:0]};

    always_comb begin
        w_wr_resp    = RespOkay;
        w_sel_ctrl   = 1'b0;
        w_sel_status = 1'b0;
        w_sel_scr    = 4'b0000;
        case (w_wr_off)
            OFF_ID, OFF_CYC_LO, OFF_CYC_HI: ;
            OFF_CTRL:   w_sel_ctrl   = 1'b1;
            OFF_STATUS: w_sel_status = 1'b1;
            OFF_SCR0:   w_sel_scr    = 4'b0001;
            OFF_SCR1:   w_sel_scr    = 4'b0010;
            OFF_SCR2:   w_sel_scr    = 4'b0100;
            OFF_SCR3:   w_sel_scr    = 4'b1000;
            default:    w_wr_resp    = RespSlverr;
        endcase
    end

    // Set wins over a same-cycle W1C clear.
    assign w_done_clr = w_commit & w_sel_status & w_wr_strb[0] & w_wr_data[1];

    always_ff @(posedge PCIE_user_Clk or negedge PCIE_user_Rst_n) begin
        if (!PCIE_user_Rst_n) begin
            r_cycle      <= '0;
            r_cyc_shadow <= '0;
            r_enable     <= 1'b0;
            r_start      <= 1'b0;
            r_done       <= 1'b0;
            for (int i = 0; i < 4; i++) r_scratch[i] <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            r_start <= w_commit & w_sel_ctrl & w_wr_strb[0] & w_wr_data[0];
            r_done  <= tst_done_i | (r_done & ~w_done_clr);
            if (w_commit && w_sel_ctrl && w_wr_strb[0]) r_enable <= w_wr_data[1];
            for (int i = 0; i < 4; i++) begin
                if (w_commit && w_sel_scr[i]) begin
                    r_scratch[i] <= apply_strb(r_scratch[i], w_wr_data, w_wr_strb);
                end
            end
            if (w_ar_hs && (w_rd_off == OFF_CYC_LO)) r_cyc_shadow <= r_cycle[63:32];
        end
    end

    assign ctrl_start_o  = r_start;
    assign ctrl_enable_o = r_enable;

    always_ff @(posedge PCIE_user_Clk or negedge PCIE_user_Rst_n) begin
        if (!PCIE_user_Rst_n) begin
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_resp;
        end else if (r_bvalid && s_axil.bready) begin
            r_bvalid <= 1'b0;
        end
    end

    assign s_axil.bvalid = r_bvalid;
    assign s_axil.bresp  = r_bresp;

    // Read mux samples pre-commit state, so a same-cycle write is not visible yet.
    always_comb begin
        w_rd_data = DEAD_BEEF;
        w_rd_resp = RespSlverr;
        case (w_rd_off)
            OFF_ID:     begin w_rd_data = ID_VALUE;                        w_rd_resp = RespOkay; end
            OFF_CTRL:   begin w_rd_data = {30'd0, r_enable, 1'b0};         w_rd_resp = RespOkay; end
            OFF_STATUS: begin w_rd_data = {30'd0, r_done, tst_busy_i};     w_rd_resp = RespOkay; end
            OFF_CYC_LO: begin w_rd_data = r_cycle[31:0];                   w_rd_resp = RespOkay; end
            OFF_CYC_HI: begin w_rd_data = r_cyc_shadow;                    w_rd_resp = RespOkay; end
            OFF_SCR0:   begin w_rd_data = r_scratch[0];                    w_rd_resp = RespOkay; end
            OFF_SCR1:   begin w_rd_data = r_scratch[1];                    w_rd_resp = RespOkay; end
            OFF_SCR2:   begin w_rd_data = r_scratch[2];                    w_rd_resp = RespOkay; end
            OFF_SCR3:   begin w_rd_data = r_scratch[3];                    w_rd_resp = RespOkay; end
            default: ;
        endcase
    end

    assign w_ar_hs       = s_axil.arvalid & r_arready;
    assign w_rvalid_next = w_ar_hs | (r_rvalid & ~s_axil.rready);

    always_ff @(posedge PCIE_user_Clk or negedge PCIE_user_Rst_n) begin
        if (!PCIE_user_Rst_n) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            r_arready <= ~w_rvalid_next;
            r_rvalid  <= w_rvalid_next;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    assign s_axil.arready = r_arready;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = r_rresp;

endmodule

// File: tb/tb_vck190_axil_responder.sv
// Directed bench for vck190_axil_responder: a table of single reads/writes plus
// hand-built sequences for split AW/W, START pulse, DONE set/clear race, counter shadow and B hold.
module tb_vck190_axil_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start;
    logic enable;
    logic busy;
    logic done;

    int n_cmp     = 0;
    int n_err     = 0;
    int start_cnt = 0;
    int bv_cnt    = 0;

    vck190_axil_responder_if #(.ADDR_W(12)) axil ();

    vck190_axil_responder #(
        .ADDR_W   (12),
        .ID_VALUE (32'h1900_0001)
    ) dut (
        .PCIE_user_Clk   (clk),
        .PCIE_user_Rst_n (rst_n),
        .s_axil          (axil),
        .ctrl_start_o    (start),
        .ctrl_enable_o   (enable),
        .tst_busy_i      (busy),
        .tst_done_i      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start) start_cnt <= start_cnt + 1;
        if (axil.bvalid) bv_cnt <= bv_cnt + 1;
    end

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Leaves time at #1 after the B handshake (or after the commit edge when bready is low).
    task automatic axil_write(input logic [11:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp,
                              output logic start_at_b);
        bit aw_ok = 0;
        bit w_ok  = 0;
        bit aw_hs;
        bit w_hs;
        int n = 0;
        @(negedge clk);
        axil.awaddr  = addr;
        axil.awvalid = 1'b1;
        axil.wdata   = data;
        axil.wstrb   = strb;
        axil.wvalid  = 1'b1;
        while (!(aw_ok && w_ok) && n < 20) begin
            aw_hs = axil.awvalid && axil.awready;
            w_hs  = axil.wvalid && axil.wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_ok = 1; axil.awvalid = 1'b0; end
            if (w_hs)  begin w_ok  = 1; axil.wvalid  = 1'b0; end
            n++;
        end
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        check("wr_handshake", {aw_ok, w_ok}, 2'b11);
        check("wr_bvalid_latency", axil.bvalid, 1'b1);
        resp       = axil.bresp;
        start_at_b = start;
        if (axil.bready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic axil_read(input logic [11:0] addr, output logic [31:0] data,
                             output logic [1:0] resp);
        bit ok = 0;
        int n  = 0;
        @(negedge clk);
        axil.araddr  = addr;
        axil.arvalid = 1'b1;
        while (!ok && n < 20) begin
            ok = axil.arready;
            @(posedge clk); #1;
            n++;
        end
        axil.arvalid = 1'b0;
        check("rd_handshake", ok, 1'b1);
        check("rd_rvalid_latency", axil.rvalid, 1'b1);
        data = axil.rdata;
        resp = axil.rresp;
        @(posedge clk); #1;
        check("rd_rvalid_drop", axil.rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] lo;
        logic [1:0]  rs;
        logic        sb;
        int          s0;
        int          b0;
        int          n;
        bit          ok;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,         4'h0, 32'h1900_0001, 2'b00};
        vecs[1]  = '{1'b1, 12'h024, 32'h1234_5678, 4'hF, 32'h0,         2'b00};
        vecs[2]  = '{1'b0, 12'h024, 32'h0,         4'h0, 32'h1234_5678, 2'b00};
        vecs[3]  = '{1'b1, 12'h024, 32'hAABB_CCDD, 4'h8, 32'h0,         2'b00};
        vecs[4]  = '{1'b0, 12'h024, 32'h0,         4'h0, 32'hAA34_5678, 2'b00};
        vecs[5]  = '{1'b1, 12'h02C, 32'hCAFE_F00D, 4'h6, 32'h0,         2'b00};
        vecs[6]  = '{1'b0, 12'h02C, 32'h0,         4'h0, 32'h00FE_F000, 2'b00};
        vecs[7]  = '{1'b1, 12'h000, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
        vecs[8]  = '{1'b0, 12'h000, 32'h0,         4'h0, 32'h1900_0001, 2'b00};
        vecs[9]  = '{1'b0, 12'h004, 32'h0,         4'h0, 32'h0000_0000, 2'b00};
        vecs[10] = '{1'b1, 12'h100, 32'h1234_5678, 4'hF, 32'h0,         2'b10};
        vecs[11] = '{1'b0, 12'h100, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b10};
        vecs[12] = '{1'b0, 12'h030, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b10};
        vecs[13] = '{1'b1, 12'h010, 32'h0000_0001, 4'hF, 32'h0,         2'b00};
        vecs[14] = '{1'b1, 12'h028, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
        vecs[15] = '{1'b0, 12'h028, 32'h0,         4'h0, 32'h1122_3344, 2'b00};

        axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0;
        axil.wvalid = 1'b0; axil.bready = 1'b1; axil.araddr = '0; axil.arvalid = 1'b0;
        axil.rready = 1'b1; busy = 1'b0; done = 1'b0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctl", {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid,
                            start, enable, axil.bresp, axil.rresp}, 11'd0);
        check("reset_rdata", axil.rdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {axil.awready, axil.wready, axil.arready}, 3'b111);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                axil_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs, sb);
                check($sformatf("vec%0d_bresp", i), rs, vecs[i].exp_resp);
            end else begin
                axil_read(vecs[i].addr, rd, rs);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), rs, vecs[i].exp_resp);
            end
        end

        // W three cycles ahead of AW to SCRATCH0.
        b0 = bv_cnt;
        @(negedge clk);
        axil.wdata = 32'hA5A5_1234; axil.wstrb = 4'b0011; axil.wvalid = 1'b1;
        ok = 0; n = 0;
        while (!ok && n < 20) begin ok = axil.wready; @(posedge clk); #1; n++; end
        axil.wvalid = 1'b0;
        check("wfirst_w_hs", ok, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("wfirst_no_b", axil.bvalid, 1'b0);
            check("wfirst_wready_low", axil.wready, 1'b0);
        end
        axil.awaddr = 12'h020; axil.awvalid = 1'b1;
        ok = 0; n = 0;
        while (!ok && n < 20) begin ok = axil.awready; @(posedge clk); #1; n++; end
        axil.awvalid = 1'b0;
        check("wfirst_aw_hs", ok, 1'b1);
        check("wfirst_bvalid", axil.bvalid, 1'b1);
        check("wfirst_bresp", axil.bresp, 2'b00);
        @(posedge clk); #1;
        check("wfirst_b_once", bv_cnt - b0, 1);
        axil_read(12'h020, rd, rs);
        check("scratch0_strb", rd, 32'h0000_1234);

        // CTRL: START pulse plus ENABLE.
        s0 = start_cnt;
        axil_write(12'h004, 32'h3, 4'hF, rs, sb);
        check("start_at_b", sb, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("start_one_cycle", start_cnt - s0, 1);
        check("enable_level", enable, 1'b1);
        axil_read(12'h004, rd, rs);
        check("ctrl_readback", rd, 32'h2);

        // STATUS: DONE sticky, set beats clear.
        busy = 1'b1;
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
        axil_read(12'h008, rd, rs);
        check("status_done_busy", rd, 32'h3);
        busy = 1'b0;
        @(negedge clk);
        check("race_ready", {axil.awready, axil.wready}, 2'b11);
        axil.awaddr = 12'h008; axil.wdata = 32'h2; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1; done = 1'b1;
        @(posedge clk); #1;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0; done = 1'b0;
        check("race_bvalid", axil.bvalid, 1'b1);
        @(posedge clk); #1;
        axil_read(12'h008, rd, rs);
        check("status_set_wins", rd, 32'h2);
        axil_write(12'h008, 32'h2, 4'b1110, rs, sb);
        axil_read(12'h008, rd, rs);
        check("status_w1c_needs_strb0", rd, 32'h2);
        axil_write(12'h008, 32'h2, 4'hF, rs, sb);
        axil_read(12'h008, rd, rs);
        check("status_w1c", rd, 32'h0);

        // Counter shadow across a low-word carry.
        @(negedge clk);
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFD;
        @(posedge clk);
        @(negedge clk);
        release dut.r_cycle;
        axil_read(12'h00C, lo, rs);
        check("cyc_lo_near_wrap", lo[31:8], 24'hFF_FFFF);
        axil_read(12'h010, rd, rs);
        check("cyc_hi_shadow", rd, 32'h0);
        axil_read(12'h00C, lo, rs);
        axil_read(12'h010, rd, rs);
        check("cyc_hi_after_carry", rd, 32'h1);

        // SLVERR with bready held low.
        axil.bready = 1'b0;
        axil_write(12'h100, 32'h0, 4'hF, rs, sb);
        repeat (5) begin
            @(negedge clk);
            check("bhold_valid", axil.bvalid, 1'b1);
            check("bhold_resp", axil.bresp, 2'b10);
        end
        axil.bready = 1'b1;
        @(posedge clk); #1;
        check("bhold_release", axil.bvalid, 1'b0);

        // Reset with a read response outstanding.
        axil.rready = 1'b0;
        axil.araddr = 12'h000; axil.arvalid = 1'b1;
        @(posedge clk); #1;
        axil.arvalid = 1'b0;
        check("rst_mid_rvalid", axil.rvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {axil.rvalid, axil.arready, enable}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        axil.rready = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ready", axil.arready, 1'b1);
        axil_read(12'h024, rd, rs);
        check("rst_scratch_cleared", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
